csa_seq_accumulator: RTL

//  Multi-operand accumulator that keeps its running total in carry-save form (sum and carry vectors).

---
 rtl/csa_seq_accumulator.sv | 119 +++++++++++
 1 files changed

// File: rtl/csa_seq_accumulator.sv
// csa_seq_accumulator: carry-save multi-operand accumulator with chunked carry-propagate resolve
module csa_seq_accumulator #(
  parameter int IN_W  = 11,
  parameter int ACC_W = 16,
  parameter int CHUNK = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [ACC_W-1:0] out_data,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_count
);
  localparam int NCHUNK = (ACC_W + CHUNK - 1) / CHUNK;
  localparam int PW     = NCHUNK * CHUNK;
  localparam int TW     = ACC_W - (NCHUNK - 1) * CHUNK;
  localparam int KW     = NCHUNK > 1 ? $clog2(NCHUNK) : 1;

  typedef enum logic [1:0] {ACCUM, RESOLVE, OUTPUT} state_t;

  state_t           state_q, state_d;
  logic [ACC_W-1:0] s_q, s_d, c_q, c_d;
  logic             sticky_q, sticky_d, cin_q, cin_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [KW-1:0]    k_q, k_d;

  logic [ACC_W-1:0] x, sn, m, cn;
  logic [CHUNK-1:0] sc, cc;
  logic [CHUNK:0]   csum;
  logic             last_k, cout;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q  <= ACCUM;
      s_q      <= '0;
      c_q      <= '0;
      sticky_q <= 1'b0;
      cin_q    <= 1'b0;
      cnt_q    <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      c_q      <= c_d;
      sticky_q <= sticky_d;
      cin_q    <= cin_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
    end

  always_comb begin
    last_k  = k_q == KW'(NCHUNK - 1);
    state_d = clr                ? ACCUM :
              state_q == ACCUM   ? (in_valid && in_last ? RESOLVE : ACCUM) :
              state_q == RESOLVE ? (last_k ? OUTPUT : RESOLVE) :
                                   (out_ready ? ACCUM : OUTPUT);
  end

  // One 3:2 compression step; the MSB of the majority vector falls off the top
  always_comb begin
    x  = ACC_W'(in_data);
    sn = s_q ^ c_q ^ x;
    m  = (s_q & c_q) | (s_q & x) | (c_q & x);
    cn = {m[ACC_W-2:0], 1'b0};
  end

  // Chunk k of the carry-propagate add; the top chunk may be narrower than CHUNK
  always_comb begin
    sc   = CHUNK'(PW'(s_q) >> (k_q * CHUNK));
    cc   = CHUNK'(PW'(c_q) >> (k_q * CHUNK));
    csum = {1'b0, sc} + {1'b0, cc} + (CHUNK + 1)'(cin_q);
    cout = last_k ? csum[TW] : csum[CHUNK];
  end

  always_comb begin
    s_d      = s_q;
    c_d      = c_q;
    sticky_d = sticky_q;
    cin_d    = cin_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    if (clr || (state_q == OUTPUT && out_ready)) begin
      s_d      = '0;
      c_d      = '0;
      sticky_d = 1'b0;
      cin_d    = 1'b0;
      cnt_d    = '0;
      k_d      = '0;
    end else if (state_q == ACCUM && in_valid) begin
      s_d      = sn;
      c_d      = cn;
      sticky_d = sticky_q | m[ACC_W-1];
      cnt_d    = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
      k_d      = '0;
      cin_d    = 1'b0;
    end else if (state_q == RESOLVE) begin
      s_d      = ACC_W'((PW'(s_q) & ~(PW'({CHUNK{1'b1}}) << (k_q * CHUNK)))
                        | (PW'(csum[CHUNK-1:0]) << (k_q * CHUNK)));
      cin_d    = cout;
      k_d      = k_q + KW'(1);
      sticky_d = sticky_q | (last_k & cout);
    end
  end

  always_comb begin
    in_ready  = state_q == ACCUM;
    out_valid = state_q == OUTPUT;
    out_data  = out_valid ? s_q : '0;
    out_ovf   = out_valid & sticky_q;
    out_count = out_valid ? cnt_q : '0;
  end
endmodule
